// File: rtl/axi_slice_cfg.sv
// axi_slice_cfg: per-channel configurable AXI4 register slice.
//
// Sits between an upstream master port (s_*) and a downstream slave port
// (m_*). Each of the five channels is either a combinational bypass
// (DEPTH = 0) or a circular FIFO of DEPTH entries (power of 2, up to 16).
// Payloads are opaque packed vectors and pass through untouched.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   s_aw_*/s_ar_*/s_w_*        request channels from upstream (valid/ready/pl)
//   m_aw_*/m_ar_*/m_w_*        request channels to downstream
//   m_r_*/m_b_*                response channels from downstream
//   s_r_*/s_b_*                response channels to upstream
//   idle_o                     1 when no buffered channel holds an entry

// Generic channel: in_* feeds out_*; empty is 1 when nothing is stored.
module axi_slice_chan #(
  parameter int unsigned PL_W  = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PL_W-1:0] in_pl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PL_W-1:0] out_pl,
  output logic            empty
);
  if (DEPTH != 0 && (DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("axi_slice_chan: DEPTH must be 0 or a power of 2 no larger than 16");
  end

  if (DEPTH == 0) begin : g_bypass
    // Pure wiring; clock and reset have no role here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign out_valid = in_valid;
    assign out_pl    = in_pl;
    assign in_ready  = out_ready;
    assign empty     = 1'b1;
  end else begin : g_fifo
    // A 1-entry FIFO still gets a 1-bit pointer; it simply never leaves 0.
    localparam int unsigned     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned     MEM_N    = 1 << PTR_W;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PL_W-1:0]  mem_p0 [MEM_N];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake flags come straight from the count register, so in_ready
    // never depends combinationally on out_ready.
    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);
    assign out_pl    = mem_p0[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end

    // Storage stage: data only, left unreset.
    always_ff @(posedge clk_i) begin
      if (push) mem_p0[wr_ptr_q] <= in_pl;
    end
  end
endmodule

module axi_slice_cfg #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AW_DEPTH       = 2,
  parameter int unsigned AR_DEPTH       = 2,
  parameter int unsigned W_DEPTH        = 2,
  parameter int unsigned R_DEPTH        = 2,
  parameter int unsigned B_DEPTH        = 2,
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  localparam int unsigned AX_W = AXI_ADDR_WIDTH + AXI_ID_WIDTH + AXI_USER_WIDTH + 29,
  localparam int unsigned W_W  = AXI_DATA_WIDTH + AXI_STRB_WIDTH + AXI_USER_WIDTH + 1,
  localparam int unsigned R_W  = AXI_DATA_WIDTH + AXI_ID_WIDTH + AXI_USER_WIDTH + 3,
  localparam int unsigned B_W  = AXI_ID_WIDTH + AXI_USER_WIDTH + 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            s_aw_valid,
  output logic            s_aw_ready,
  input  logic [AX_W-1:0] s_aw_pl,
  output logic            m_aw_valid,
  input  logic            m_aw_ready,
  output logic [AX_W-1:0] m_aw_pl,
  input  logic            s_ar_valid,
  output logic            s_ar_ready,
  input  logic [AX_W-1:0] s_ar_pl,
  output logic            m_ar_valid,
  input  logic            m_ar_ready,
  output logic [AX_W-1:0] m_ar_pl,
  input  logic            s_w_valid,
  output logic            s_w_ready,
  input  logic [W_W-1:0]  s_w_pl,
  output logic            m_w_valid,
  input  logic            m_w_ready,
  output logic [W_W-1:0]  m_w_pl,
  output logic            s_r_valid,
  input  logic            s_r_ready,
  output logic [R_W-1:0]  s_r_pl,
  input  logic            m_r_valid,
  output logic            m_r_ready,
  input  logic [R_W-1:0]  m_r_pl,
  output logic            s_b_valid,
  input  logic            s_b_ready,
  output logic [B_W-1:0]  s_b_pl,
  input  logic            m_b_valid,
  output logic            m_b_ready,
  input  logic [B_W-1:0]  m_b_pl,
  output logic            idle_o
);
  logic aw_empty, ar_empty, w_empty, r_empty, b_empty;

  axi_slice_chan #(.PL_W(AX_W), .DEPTH(AW_DEPTH)) u_aw (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid(s_aw_valid), .in_ready(s_aw_ready), .in_pl(s_aw_pl),
    .out_valid(m_aw_valid), .out_ready(m_aw_ready), .out_pl(m_aw_pl),
    .empty(aw_empty)
  );

  axi_slice_chan #(.PL_W(AX_W), .DEPTH(AR_DEPTH)) u_ar (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid(s_ar_valid), .in_ready(s_ar_ready), .in_pl(s_ar_pl),
    .out_valid(m_ar_valid), .out_ready(m_ar_ready), .out_pl(m_ar_pl),
    .empty(ar_empty)
  );

  axi_slice_chan #(.PL_W(W_W), .DEPTH(W_DEPTH)) u_w (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid(s_w_valid), .in_ready(s_w_ready), .in_pl(s_w_pl),
    .out_valid(m_w_valid), .out_ready(m_w_ready), .out_pl(m_w_pl),
    .empty(w_empty)
  );

  // Response channels run downstream -> upstream.
  axi_slice_chan #(.PL_W(R_W), .DEPTH(R_DEPTH)) u_r (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid(m_r_valid), .in_ready(m_r_ready), .in_pl(m_r_pl),
    .out_valid(s_r_valid), .out_ready(s_r_ready), .out_pl(s_r_pl),
    .empty(r_empty)
  );

  axi_slice_chan #(.PL_W(B_W), .DEPTH(B_DEPTH)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid(m_b_valid), .in_ready(m_b_ready), .in_pl(m_b_pl),
    .out_valid(s_b_valid), .out_ready(s_b_ready), .out_pl(s_b_pl),
    .empty(b_empty)
  );

  // Bypass channels report empty permanently, so they drop out of the AND.
  assign idle_o = aw_empty & ar_empty & w_empty & r_empty & b_empty;
endmodule

// File: tb/tb_axi_slice_cfg.sv
`timescale 1ns/1ps
module tb_axi_slice_cfg;
  localparam int AX_W = 73;
  localparam int W_W  = 79;
  localparam int R_W  = 79;
  localparam int B_W  = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Channel index k: 0..4 = dut0 AW,AR,W,R,B ; 5..9 = dut1 AW,AR,W,R,B.
  // in/out are taken in the direction of data flow for each channel.
  logic         iv   [10];
  logic         ir   [10];
  logic [127:0] ipl  [10];
  logic         ov   [10];
  logic         ordy [10];
  logic [127:0] opl  [10];
  logic         idle [2];
  logic [127:0] mask [10];
  int unsigned  wid  [5] = '{AX_W, AX_W, W_W, R_W, B_W};

  logic [127:0] sb      [10][$];
  logic         held    [10];
  logic [127:0] held_pl [10];
  logic         acc     [10];

  int checks = 0;
  int errors = 0;

  // dut0: AW=16, AR=bypass, W=2, R=4, B=2
  axi_slice_cfg #(.AW_DEPTH(16), .AR_DEPTH(0), .W_DEPTH(2), .R_DEPTH(4), .B_DEPTH(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .s_aw_valid(iv[0]), .s_aw_ready(ir[0]), .s_aw_pl(ipl[0][AX_W-1:0]),
    .m_aw_valid(ov[0]), .m_aw_ready(ordy[0]), .m_aw_pl(opl[0][AX_W-1:0]),
    .s_ar_valid(iv[1]), .s_ar_ready(ir[1]), .s_ar_pl(ipl[1][AX_W-1:0]),
    .m_ar_valid(ov[1]), .m_ar_ready(ordy[1]), .m_ar_pl(opl[1][AX_W-1:0]),
    .s_w_valid(iv[2]), .s_w_ready(ir[2]), .s_w_pl(ipl[2][W_W-1:0]),
    .m_w_valid(ov[2]), .m_w_ready(ordy[2]), .m_w_pl(opl[2][W_W-1:0]),
    .m_r_valid(iv[3]), .m_r_ready(ir[3]), .m_r_pl(ipl[3][R_W-1:0]),
    .s_r_valid(ov[3]), .s_r_ready(ordy[3]), .s_r_pl(opl[3][R_W-1:0]),
    .m_b_valid(iv[4]), .m_b_ready(ir[4]), .m_b_pl(ipl[4][B_W-1:0]),
    .s_b_valid(ov[4]), .s_b_ready(ordy[4]), .s_b_pl(opl[4][B_W-1:0]),
    .idle_o(idle[0])
  );

  // dut1: every channel a single-entry buffer
  axi_slice_cfg #(.AW_DEPTH(1), .AR_DEPTH(1), .W_DEPTH(1), .R_DEPTH(1), .B_DEPTH(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .s_aw_valid(iv[5]), .s_aw_ready(ir[5]), .s_aw_pl(ipl[5][AX_W-1:0]),
    .m_aw_valid(ov[5]), .m_aw_ready(ordy[5]), .m_aw_pl(opl[5][AX_W-1:0]),
    .s_ar_valid(iv[6]), .s_ar_ready(ir[6]), .s_ar_pl(ipl[6][AX_W-1:0]),
    .m_ar_valid(ov[6]), .m_ar_ready(ordy[6]), .m_ar_pl(opl[6][AX_W-1:0]),
    .s_w_valid(iv[7]), .s_w_ready(ir[7]), .s_w_pl(ipl[7][W_W-1:0]),
    .m_w_valid(ov[7]), .m_w_ready(ordy[7]), .m_w_pl(opl[7][W_W-1:0]),
    .m_r_valid(iv[8]), .m_r_ready(ir[8]), .m_r_pl(ipl[8][R_W-1:0]),
    .s_r_valid(ov[8]), .s_r_ready(ordy[8]), .s_r_pl(opl[8][R_W-1:0]),
    .m_b_valid(iv[9]), .m_b_ready(ir[9]), .m_b_pl(ipl[9][B_W-1:0]),
    .s_b_valid(ov[9]), .s_b_ready(ordy[9]), .s_b_pl(opl[9][B_W-1:0]),
    .idle_o(idle[1])
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Inputs change at posedge+1; handshakes are judged at the negedge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: records accepted beats, pops and compares delivered beats,
  // and checks that a stalled output stays put.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 10; k++) begin
        sb[k].delete();
        held[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 10; k++) begin
        if (iv[k] && ir[k]) sb[k].push_back(ipl[k] & mask[k]);
        if (held[k]) begin
          chk($sformatf("ch%0d_stall_valid", k), ov[k], 1'b1);
          chk($sformatf("ch%0d_stall_pl", k), opl[k] & mask[k], held_pl[k]);
        end
        if (ov[k] && ordy[k]) begin
          if (sb[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ch%0d_extra_beat got=%0h want=no_beat", k, opl[k] & mask[k]);
          end else begin
            chk($sformatf("ch%0d_order", k), opl[k] & mask[k], sb[k].pop_front());
          end
        end
        // The bypass channel's stability is whatever the bench drives.
        held[k]    = ov[k] && !ordy[k] && (k != 1);
        held_pl[k] = opl[k] & mask[k];
      end
    end
  end

  initial begin
    for (int k = 0; k < 10; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b1;
      ipl[k]  = '0;
      held[k] = 1'b0;
      mask[k] = (128'd1 << wid[k % 5]) - 128'd1;
    end

    // Reset state
    #3;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("rst_out_valid_ch%0d", c), ov[c], 1'b0);
      if (c != 1) chk($sformatf("rst_in_ready_ch%0d", c), ir[c], 1'b1);
    end
    chk("rst_idle0", idle[0], 1'b1);
    chk("rst_idle1", idle[1], 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset in the middle of a 2-beat AW burst
    cyc();
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    ipl[0] = 128'hA1;
    cyc();
    ipl[0] = 128'hA2;
    cyc();
    iv[0] = 1'b0;
    @(negedge clk);
    chk("aw_burst_valid", ov[0], 1'b1);
    chk("aw_burst_idle", idle[0], 1'b0);
    cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("aw_rst_valid", ov[0], 1'b0);
    chk("aw_rst_ready", ir[0], 1'b1);
    chk("aw_rst_idle", idle[0], 1'b1);
    cyc();
    rst_n = 1'b1;
    ordy[0] = 1'b1;

    // W throughput: 8 back-to-back beats, depth 2
    ordy[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      iv[2] = (i < 8);
      ipl[2] = 128'h5700 + 128'(i);
      @(negedge clk);
      chk($sformatf("w_tput_valid_%0d", i), ov[2], (i >= 1 && i <= 8));
      chk($sformatf("w_tput_ready_%0d", i), ir[2], 1'b1);
    end
    iv[2] = 1'b0;

    // R full/backpressure: depth 4, five beats, release later
    ordy[3] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i < 5) begin
        iv[3] = 1'b1;
        ipl[3] = 128'h5200 + 128'(i);
      end
      if (i == 6) ordy[3] = 1'b1;
      if (i == 8) iv[3] = 1'b0;
      @(negedge clk);
      if (i <= 7) chk($sformatf("r_full_ready_%0d", i), ir[3], (i < 4 || i == 7));
      chk($sformatf("r_full_valid_%0d", i), ov[3], (i >= 1 && i <= 10));
    end
    chk("r_drained_idle", idle[0], 1'b1);

    // AR bypass: zero-cycle pass-through
    for (int i = 0; i < 4; i++) begin
      cyc();
      iv[1] = i[0];
      ordy[1] = i[1];
      ipl[1] = 128'hA400 + 128'(i);
      #1;
      chk($sformatf("ar_byp_valid_%0d", i), ov[1], i[0]);
      chk($sformatf("ar_byp_ready_%0d", i), ir[1], i[1]);
      chk($sformatf("ar_byp_pl_%0d", i), opl[1] & mask[1], 128'hA400 + 128'(i));
      chk($sformatf("ar_byp_idle_%0d", i), idle[0], 1'b1);
    end
    cyc();
    iv[1] = 1'b0;
    ordy[1] = 1'b1;

    // B depth 2: hold count at 1 with push+pop each cycle
    ordy[4] = 1'b0;
    cyc();
    iv[4] = 1'b1;
    ipl[4] = 128'hB00;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      ordy[4] = 1'b1;
      ipl[4] = 128'hB00 + 128'(i);
      @(negedge clk);
      chk($sformatf("b_pp_valid_%0d", i), ov[4], 1'b1);
      chk($sformatf("b_pp_ready_%0d", i), ir[4], 1'b1);
      chk($sformatf("b_pp_idle_%0d", i), idle[0], 1'b0);
    end
    cyc();
    iv[4] = 1'b0;
    cyc();
    @(negedge clk);
    chk("b_pp_drain_valid", ov[4], 1'b0);
    chk("b_pp_drain_idle", idle[0], 1'b1);

    // Random valid/ready on every channel of both instances
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int k = 0; k < 10; k++) acc[k] = iv[k] && ir[k];
      cyc();
      for (int k = 0; k < 10; k++) begin
        if (!iv[k] || acc[k]) begin
          iv[k] = ($urandom_range(0, 2) != 0);
          ipl[k] = {$urandom, $urandom, $urandom, $urandom};
        end
        if (((n / 250) % 2) == 1) ordy[k] = ($urandom_range(0, 3) == 0);
        else ordy[k] = ($urandom_range(0, 2) != 0);
      end
    end
    cyc();
    for (int k = 0; k < 10; k++) begin
      iv[k] = 1'b0;
      ordy[k] = 1'b1;
    end
    repeat (40) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("rand_left_ch%0d", k), 128'(sb[k].size()), 128'd0);
      chk($sformatf("rand_valid_end_ch%0d", k), ov[k], 1'b0);
    end
    chk("rand_idle0", idle[0], 1'b1);
    chk("rand_idle1", idle[1], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
